// File: rtl/oled_spi_write_if.sv
// rtl/oled_spi_write_if.sv - byte request / completion handshake between the sequencers and the OLED SPI writer
interface oled_spi_write_if;
  logic       ena_write;
  logic [7:0] data;
  logic       oled_dc;
  logic       write_done;
  logic       busy;

  modport master (output ena_write, data, oled_dc, input write_done, busy);
  modport slave  (input ena_write, data, oled_dc, output write_done, busy);
endinterface

// File: rtl/oled_spi_write.sv
// rtl/oled_spi_write.sv - SPI mode-0 byte writer for the SSD1306 panel (CS/DC framing, MSB first)
// OLED_SPI_PEND_EN adds a one-entry pending buffer so a request made while busy is chained.
module oled_spi_write #(
  parameter int CLK_DIV = 2
) (
  input  logic            clk,
  input  logic            rst,
  oled_spi_write_if.slave req,
  output logic            spi_sclk,
  output logic            spi_mosi,
  output logic            spi_cs_n,
  output logic            spi_dc
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FINISH} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, state_nx;
  logic [7:0] div_cnt, div_cnt_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic       bits_done, bits_done_nx;
  logic [7:0] shreg, shreg_nx;
  logic       sclk_nx, mosi_nx, cs_n_nx, dc_nx;
  logic       write_done, write_done_nx;
  logic       busy, busy_nx;
  logic       launch;
  logic [7:0] launch_data;
  logic       launch_dc;
  logic       div_end;

`ifdef OLED_SPI_PEND_EN
  logic       pend_valid, pend_valid_nx;
  logic [7:0] pend_data, pend_data_nx;
  logic       pend_dc, pend_dc_nx;
`endif

  // Counter stops at CLK_DIV-1, so CLK_DIV=255 never reaches the 8-bit wrap.
  assign div_end        = (div_cnt == DIV_LAST);
  assign req.write_done = write_done;
  assign req.busy       = busy;

  always_comb begin
    state_nx      = state;
    div_cnt_nx    = div_cnt;
    bit_cnt_nx    = bit_cnt;
    bits_done_nx  = bits_done;
    shreg_nx      = shreg;
    sclk_nx       = spi_sclk;
    mosi_nx       = spi_mosi;
    cs_n_nx       = spi_cs_n;
    dc_nx         = spi_dc;
    write_done_nx = 1'b0;
    busy_nx       = busy;
    launch        = 1'b0;
    launch_data   = req.data;
    launch_dc     = req.oled_dc;
`ifdef OLED_SPI_PEND_EN
    pend_valid_nx = pend_valid;
    pend_data_nx  = pend_data;
    pend_dc_nx    = pend_dc;
`endif

    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (req.ena_write) launch = 1'b1;
      end
      SETUP: begin
        if (div_end) begin
          state_nx   = HIGH;
          div_cnt_nx = 8'd0;
          sclk_nx    = 1'b1;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end
      HIGH: begin
        if (div_end) begin
          state_nx   = LOW;
          div_cnt_nx = 8'd0;
          sclk_nx    = 1'b0;
          // Falling edge: present the next bit while SCLK is low.
          shreg_nx   = {shreg[6:0], 1'b0};
          mosi_nx    = shreg[6];
          if (bit_cnt == 3'd7) bits_done_nx = 1'b1;
          else                 bit_cnt_nx   = bit_cnt + 3'd1;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end
      LOW: begin
        if (div_end) begin
          div_cnt_nx = 8'd0;
          if (bits_done) begin
            state_nx = FINISH;
            cs_n_nx  = 1'b1;
            mosi_nx  = 1'b0;
          end else begin
            state_nx = HIGH;
            sclk_nx  = 1'b1;
          end
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end
      FINISH: begin
        state_nx      = IDLE;
        write_done_nx = 1'b1;
`ifdef OLED_SPI_PEND_EN
        if (pend_valid) begin
          launch        = 1'b1;
          launch_data   = pend_data;
          launch_dc     = pend_dc;
          pend_valid_nx = 1'b0;
        end else if (req.ena_write) begin
          launch = 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase

`ifdef OLED_SPI_PEND_EN
    if ((state == SETUP || state == HIGH || state == LOW) && req.ena_write && !pend_valid) begin
      pend_valid_nx = 1'b1;
      pend_data_nx  = req.data;
      pend_dc_nx    = req.oled_dc;
    end
`endif

    if (launch) begin
      state_nx     = SETUP;
      div_cnt_nx   = 8'd0;
      bit_cnt_nx   = 3'd0;
      bits_done_nx = 1'b0;
      shreg_nx     = launch_data;
      mosi_nx      = launch_data[7];
      cs_n_nx      = 1'b0;
      dc_nx        = launch_dc;
      busy_nx      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= 3'd0;
      bits_done  <= 1'b0;
      shreg      <= 8'd0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_dc     <= 1'b1;
      write_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      div_cnt    <= div_cnt_nx;
      bit_cnt    <= bit_cnt_nx;
      bits_done  <= bits_done_nx;
      shreg      <= shreg_nx;
      spi_sclk   <= sclk_nx;
      spi_mosi   <= mosi_nx;
      spi_cs_n   <= cs_n_nx;
      spi_dc     <= dc_nx;
      write_done <= write_done_nx;
      busy       <= busy_nx;
    end
  end

`ifdef OLED_SPI_PEND_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= 8'd0;
      pend_dc    <= 1'b0;
    end else begin
      pend_valid <= pend_valid_nx;
      pend_data  <= pend_data_nx;
      pend_dc    <= pend_dc_nx;
    end
  end
`endif

endmodule

// File: tb/tb_oled_spi_write.sv
// tb/tb_oled_spi_write.sv - randomized self-checking bench for oled_spi_write at CLK_DIV 2, 1 and 255
`timescale 1ns/1ps
module tb_oled_spi_write;
  localparam int NDUT = 3;
`ifdef OLED_SPI_PEND_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  function automatic int div_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 255);
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       ena   [NDUT];
  logic [7:0] dat   [NDUT];
  logic       dcin  [NDUT];
  logic       o_done[NDUT];
  logic       o_busy[NDUT];
  logic       o_sclk[NDUT];
  logic       o_mosi[NDUT];
  logic       o_cs_n[NDUT];
  logic       o_dc  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    oled_spi_write_if bus ();
    assign bus.ena_write = ena[g];
    assign bus.data      = dat[g];
    assign bus.oled_dc   = dcin[g];
    assign o_done[g]     = bus.write_done;
    assign o_busy[g]     = bus.busy;
    oled_spi_write #(.CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 255))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (bus),
      .spi_sclk (o_sclk[g]),
      .spi_mosi (o_mosi[g]),
      .spi_cs_n (o_cs_n[g]),
      .spi_dc   (o_dc[g])
    );
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int g, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d want %0d at %0t", nm, g, act, exp, $time);
    end
  endfunction

  // Behavioural model: each byte is described only by its accept edge; outputs follow from the cycle offset.
  int         n_edge [NDUT];
  bit         valid  [NDUT];
  int         a_cur  [NDUT];
  bit         pvalid [NDUT];
  int         a_prev [NDUT];
  logic [7:0] cur_d  [NDUT];
  logic       dc_last[NDUT];
  bit         pend_v [NDUT];
  logic [7:0] pend_d [NDUT];
  logic       pend_dc[NDUT];
  logic [7:0] exp_q  [NDUT][$];
  logic [7:0] rx_sh  [NDUT];
  logic [7:0] last_rx[NDUT];
  int         rises  [NDUT];
  logic       prev_sclk[NDUT];
  int         done_cnt [NDUT];

  function automatic void model_reset(int g);
    valid[g] = 0; pvalid[g] = 0; pend_v[g] = 0; dc_last[g] = 1'b1;
    exp_q[g].delete();
    rises[g] = 0; prev_sclk[g] = 1'b0; rx_sh[g] = 8'd0;
  endfunction

  function automatic void model_start(int g, logic [7:0] d, logic dc);
    a_prev[g] = a_cur[g]; pvalid[g] = valid[g];
    a_cur[g] = n_edge[g]; valid[g] = 1;
    cur_d[g] = d; dc_last[g] = dc;
    exp_q[g].push_back(d);
  endfunction

  function automatic void model_step(int g);
    int d, t;
    d = div_of(g);
    t = n_edge[g] - a_cur[g];
    if (valid[g] && t == 17*d + 1) begin
      if (pend_v[g]) begin
        model_start(g, pend_d[g], pend_dc[g]);
        pend_v[g] = 0;
      end else if (PEND && ena[g]) begin
        model_start(g, dat[g], dcin[g]);
      end
    end else if (!valid[g] || t >= 17*d + 2) begin
      if (ena[g]) model_start(g, dat[g], dcin[g]);
    end else if (PEND && ena[g] && !pend_v[g]) begin
      pend_v[g] = 1; pend_d[g] = dat[g]; pend_dc[g] = dcin[g];
    end
  endfunction

  function automatic void compare(int g);
    int d, t, b;
    logic e_cs, e_sclk, e_mosi, e_done, e_busy;
    d = div_of(g);
    t = n_edge[g] - a_cur[g];
    e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0;
    if (valid[g] && t < 17*d) begin
      e_cs   = 1'b0;
      e_sclk = (t >= d) && (((t - d) / d) % 2 == 0);
      b      = (t < 2*d) ? 0 : (t - 2*d) / (2*d) + 1;
      e_mosi = (b < 8) ? cur_d[g][7-b] : 1'b0;
    end
    if (valid[g] && t <= 17*d + 1) e_busy = 1'b1;
    e_done = (valid[g] && t == 17*d + 1) || (pvalid[g] && (n_edge[g] - a_prev[g]) == 17*d + 1);
    chk("cs_n", g, o_cs_n[g], e_cs);
    chk("sclk", g, o_sclk[g], e_sclk);
    chk("mosi", g, o_mosi[g], e_mosi);
    chk("write_done", g, o_done[g], e_done);
    chk("busy", g, o_busy[g], e_busy);
    chk("spi_dc", g, o_dc[g], dc_last[g]);
    // Scoreboard: rebuild the byte from MOSI at each SCLK rise.
    if (o_sclk[g] && !prev_sclk[g]) begin
      rx_sh[g] = {rx_sh[g][6:0], o_mosi[g]};
      rises[g]++;
    end
    prev_sclk[g] = o_sclk[g];
    if (o_done[g]) begin
      done_cnt[g]++;
      chk("sclk_rises", g, rises[g], 8);
      rises[g] = 0;
      last_rx[g] = rx_sh[g];
      if (exp_q[g].size() == 0) chk("sb_unexpected_byte", g, rx_sh[g], -1);
      else chk("sb_byte", g, rx_sh[g], exp_q[g].pop_front());
    end
  endfunction

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      n_edge[g] = 0; a_cur[g] = 0; a_prev[g] = 0; done_cnt[g] = 0; last_rx[g] = 8'd0;
      model_reset(g);
    end
    forever begin
      @(posedge clk);
      for (int g = 0; g < NDUT; g++) begin
        n_edge[g]++;
        if (rst) model_reset(g);
        else model_step(g);
      end
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (rst) begin
          chk("rst_cs_n", g, o_cs_n[g], 1);
          chk("rst_sclk", g, o_sclk[g], 0);
          chk("rst_done", g, o_done[g], 0);
          model_reset(g);
        end else begin
          compare(g);
        end
      end
    end
  end

  task automatic pulse(int g, logic [7:0] d, logic dc);
    @(posedge clk); #1;
    ena[g] = 1'b1; dat[g] = d; dcin[g] = dc;
    @(posedge clk); #1;
    ena[g] = 1'b0;
  endtask

  task automatic wait_done(int g, int bound, output int lat, output int csl);
    bit ok;
    ok = 0; lat = 0; csl = (o_cs_n[g] == 1'b0) ? 1 : 0;
    while (lat < bound) begin
      @(posedge clk); #1;
      lat++;
      if (o_done[g]) begin ok = 1; break; end
      if (!o_cs_n[g]) csl++;
    end
    if (!ok) chk("write_done_timeout", g, 0, 1);
  endtask

  task automatic xfer(int g, logic [7:0] d, logic dc, int exp_lat);
    int lat, csl;
    pulse(g, d, dc);
    wait_done(g, exp_lat + 20, lat, csl);
    chk("latency", g, lat, exp_lat);
    chk("cs_low_cycles", g, csl, exp_lat - 1);
    chk("dc_held", g, o_dc[g], dc);
    @(negedge clk); #1;
    chk("rx_byte", g, last_rx[g], d);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_sclk"}, 0, o_sclk[0], 0);
    chk({tag, "_mosi"}, 0, o_mosi[0], 0);
    chk({tag, "_cs_n"}, 0, o_cs_n[0], 1);
    chk({tag, "_dc"},   0, o_dc[0], 1);
    chk({tag, "_done"}, 0, o_done[0], 0);
    chk({tag, "_busy"}, 0, o_busy[0], 0);
  endtask

  initial begin
    int lat, csl, base, seen_low, hi_run, gap;
    rst = 1'b1;
    for (int g = 0; g < NDUT; g++) begin ena[g] = 1'b0; dat[g] = 8'd0; dcin[g] = 1'b0; end
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;

    xfer(0, 8'hB7, 1'b0, 35);

    pulse(0, 8'hA5, 1'b1);
    dat[0] = 8'h00;
    wait_done(0, 60, lat, csl);
    chk("a5_latency", 0, lat, 35);
    chk("a5_dc", 0, o_dc[0], 1);
    @(negedge clk); #1;
    chk("a5_rx", 0, last_rx[0], 8'hA5);

    // Second request five cycles into a byte.
    base = done_cnt[0];
    pulse(0, 8'h3E, 1'b1);
    repeat (4) @(posedge clk);
    pulse(0, 8'hC1, 1'b0);
    seen_low = 1; hi_run = 0; gap = -1;
    repeat (82) begin
      @(posedge clk); #1;
      if (!o_cs_n[0]) begin
        if (seen_low != 0 && hi_run > 0 && gap < 0) gap = hi_run;
        seen_low = 1; hi_run = 0;
      end else begin
        hi_run++;
      end
    end
    chk("busy_req_dones", 0, done_cnt[0] - base, PEND ? 2 : 1);
    chk("busy_req_cs_gap", 0, gap, PEND ? 1 : -1);

    // Upstream sequencer: next byte issued the cycle after each write_done.
    base = done_cnt[0];
    for (int i = 0; i < 1024; i++) begin
      pulse(0, 8'($urandom), 1'($urandom));
      wait_done(0, 60, lat, csl);
    end
    @(negedge clk); #1;
    chk("seq_dones", 0, done_cnt[0] - base, 1024);
    chk("seq_queue_left", 0, exp_q[0].size(), 0);

    // ena_write held high with changing data.
    @(posedge clk); #1;
    ena[0] = 1'b1;
    repeat (120) begin
      dat[0] = 8'($urandom); dcin[0] = 1'($urandom);
      @(posedge clk); #1;
    end
    ena[0] = 1'b0;
    repeat (80) @(posedge clk);

    // Reset at bit 4 of a byte.
    pulse(0, 8'h3C, 1'b0);
    repeat (17) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    base = done_cnt[0];
    @(posedge clk); #2 rst = 1'b0;
    repeat (50) @(posedge clk);
    #1 chk("aborted_no_done", 0, done_cnt[0] - base, 0);
    xfer(0, 8'h5A, 1'b0, 35);

    xfer(1, 8'hFF, 1'b1, 18);
    xfer(1, 8'h00, 1'b0, 18);
    xfer(2, 8'hFF, 1'b0, 4336);
    xfer(2, 8'h00, 1'b1, 4336);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
